// File: rtl/tuner_fft_frame_ctrl.sv
// Frame sequencer for the tuner FFT: feeds N real samples as one sop..eop packet
// and scans the returned spectrum for the strongest bin in 1..N/2-1.
module tuner_fft_frame_ctrl #(
  parameter int LOG2N = 12,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             smp_valid,
  output logic             smp_ready,
  input  logic [DW-1:0]    smp_data,
  output logic             fft_sink_valid,
  input  logic             fft_sink_ready,
  output logic             fft_sink_sop,
  output logic             fft_sink_eop,
  output logic [DW-1:0]    fft_sink_real,
  output logic [DW-1:0]    fft_sink_imag,
  output logic [1:0]       fft_sink_error,
  output logic [13:0]      fft_fftpts_in,
  input  logic             fft_source_valid,
  output logic             fft_source_ready,
  input  logic [1:0]       fft_source_error,
  input  logic             fft_source_sop,
  input  logic             fft_source_eop,
  input  logic [DW-1:0]    fft_source_real,
  input  logic [DW-1:0]    fft_source_imag,
  output logic             peak_valid,
  output logic [LOG2N-2:0] peak_bin,
  output logic [DW:0]      peak_mag,
  output logic             frame_err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;
  localparam logic [LOG2N-1:0] HALF_IDX = {1'b1, {(LOG2N-1){1'b0}}};
  localparam logic [LOG2N-1:0] ONE_IDX  = {{(LOG2N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FEED = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [LOG2N-1:0] r_in_cnt;
  logic             w_accept;

  logic [LOG2N-1:0] r_bin_cnt, r_max_bin;
  logic [DW:0]      r_max;
  logic             r_err;
  logic             r_src_ready, r_peak_valid, r_frame_err;
  logic [LOG2N-2:0] r_peak_bin;
  logic [DW:0]      r_peak_mag;

  logic [LOG2N-1:0] w_bin, w_cur_bin, w_max_bin_nxt;
  logic [DW:0]      w_mag, w_cur_max, w_max_nxt;
  logic             w_err_nxt;

  // Exact magnitude of a signed value; the extra bit holds |-2**(DW-1)| without saturation.
  function automatic logic [DW:0] f_abs(input logic [DW-1:0] v);
    logic [DW:0] e;
    e = {v[DW-1], v};
    if (v[DW-1]) begin
      return -e;
    end else begin
      return e;
    end
  endfunction

  assign fft_sink_real    = smp_data;
  assign fft_sink_imag    = '0;
  assign fft_sink_error   = 2'b00;
  assign fft_fftpts_in    = 14'(N);
  assign fft_source_ready = r_src_ready;
  assign peak_valid       = r_peak_valid;
  assign peak_bin         = r_peak_bin;
  assign peak_mag         = r_peak_mag;
  assign frame_err        = r_frame_err;

  // Input FSM next state and zero-latency sample/sink handshake.
  always_comb begin
    w_state_nxt    = r_state;
    smp_ready      = 1'b0;
    fft_sink_valid = 1'b0;
    fft_sink_sop   = 1'b0;
    fft_sink_eop   = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_FEED;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FEED: begin
        fft_sink_valid = smp_valid;
        smp_ready      = fft_sink_ready;
        w_accept       = smp_valid & fft_sink_ready;
        fft_sink_sop   = smp_valid & (r_in_cnt == '0);
        fft_sink_eop   = smp_valid & (r_in_cnt == LAST_IDX);
        // A frame always runs to N beats; enable is only honoured at the frame boundary.
        if (w_accept && (r_in_cnt == LAST_IDX) && !enable) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FEED;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Input FSM state and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_in_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_in_cnt <= r_in_cnt + ONE_IDX;
      end else begin
        r_in_cnt <= r_in_cnt;
      end
    end
  end

  // Spectrum scan: fold the current beat into the running max so the eop bin is included.
  always_comb begin
    w_bin     = fft_source_sop ? '0 : r_bin_cnt;
    w_mag     = f_abs(fft_source_real) + f_abs(fft_source_imag);
    w_cur_max = fft_source_sop ? '0 : r_max;
    w_cur_bin = fft_source_sop ? '0 : r_max_bin;
    w_err_nxt = (fft_source_sop ? (r_bin_cnt != '0) : r_err)
              | (fft_source_error != 2'b00)
              | (fft_source_eop & (w_bin != LAST_IDX));
    if ((w_bin != '0) && (w_bin < HALF_IDX) && (w_mag > w_cur_max)) begin
      w_max_nxt     = w_mag;
      w_max_bin_nxt = w_bin;
    end else begin
      w_max_nxt     = w_cur_max;
      w_max_bin_nxt = w_cur_bin;
    end
  end

  // Scan state and once-per-frame peak report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src_ready  <= 1'b1;
      r_bin_cnt    <= '0;
      r_max        <= '0;
      r_max_bin    <= '0;
      r_err        <= 1'b0;
      r_peak_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
    end else begin
      r_src_ready  <= 1'b1;
      r_peak_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (fft_source_valid) begin
        r_bin_cnt <= fft_source_eop ? '0 : (w_bin + ONE_IDX);
        r_err     <= w_err_nxt;
        r_max     <= w_max_nxt;
        r_max_bin <= w_max_bin_nxt;
        if (fft_source_eop) begin
          if (w_err_nxt) begin
            r_frame_err <= 1'b1;
          end else begin
            r_peak_valid <= 1'b1;
            r_peak_bin   <= w_max_bin_nxt[LOG2N-2:0];
            r_peak_mag   <= w_max_nxt;
          end
        end else begin
          r_frame_err <= 1'b0;
        end
      end else begin
        r_bin_cnt <= r_bin_cnt;
      end
    end
  end

endmodule
